// File: rtl/rv32i_multicycle_ctrl_if.sv
// Fetch/data handshake and control-word bundle between the RV32I control FSM
// (master) and the datapath/memories (slave).
interface rv32i_multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] inst;
    logic        dmem_ready;
    logic        br_taken;
    logic [22:0] cword;

    modport master (
        output imem_req, cword,
        input  imem_ready, inst, dmem_ready, br_taken
    );

    modport slave (
        input  imem_req, cword,
        output imem_ready, inst, dmem_ready, br_taken
    );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: fetch handshake, IR, control word, retire count.
// Build option ILLEGAL_TRAP_EN: illegal opcodes trap to HALT instead of retiring as a NOP.
//
// state  | meaning
// IDLE   | out of reset, fetch starts next cycle
// FETCH  | imem_req high, waiting for imem_ready
// DECODE | IR holds the instruction, inst_type valid
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | load/store handshake, waiting for dmem_ready
// WB     | register write-back, PC update, retire
// HALT   | handshake timeout or trap, left only by reset
module rv32i_multicycle_ctrl #(
    parameter int FETCH_WAIT_MAX = 255,
    parameter int PERF_CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rv32i_multicycle_ctrl_if.master bus,
    output logic [PERF_CNT_W-1:0]   instret,
    output logic                    timeout,
    output logic                    trap
);
    localparam int WAIT_W = (FETCH_WAIT_MAX > 1) ? $clog2(FETCH_WAIT_MAX) : 1;

    localparam logic [3:0] T_LOAD  = 4'd0;
    localparam logic [3:0] T_IMM   = 4'd1;
    localparam logic [3:0] T_STORE = 4'd2;
    localparam logic [3:0] T_REG   = 4'd3;
    localparam logic [3:0] T_LUI   = 4'd4;
    localparam logic [3:0] T_AUIPC = 4'd5;
    localparam logic [3:0] T_BRNCH = 4'd6;
    localparam logic [3:0] T_JALR  = 4'd7;
    localparam logic [3:0] T_JAL   = 4'd8;
    localparam logic [3:0] T_ILL   = 4'hF;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       br_eval;
        logic       f7b5;
        logic [2:0] funct3;
        logic [1:0] wb_sel;
        logic       mem_wr;
        logic       mem_rd;
        logic       b_sel;
        logic       a_sel;
        logic       rf_we;
        logic       pc_sel;
        logic       pc_we;
        logic       ir_we;
        logic [3:0] inst_type;
    } cword_t;

    state_t            state, state_nx;
    cword_t            cw;
    logic [31:0]       ir;
    logic [3:0]        itype;
    logic [3:0]        alu_op;
    logic [WAIT_W-1:0] wait_cnt;
    logic              imem_req;
    logic              stall;
    logic              wait_lim;
    logic              retire;
    logic              to_hit;
    logic              rd_nz;
    logic              is_jump;
    logic              ir_unused;
`ifdef ILLEGAL_TRAP_EN
    logic              trap_hit;
`endif

    // Immediate bits are consumed by immed_gen from its own copy of the instruction.
    assign ir_unused = ^{ir[31], ir[29:15]};

    assign rd_nz    = |ir[11:7];
    assign is_jump  = (itype == T_JAL) || (itype == T_JALR);
    assign stall    = ((state == FETCH) && !bus.imem_ready) ||
                      ((state == MEM) && !bus.dmem_ready);
    assign wait_lim = (FETCH_WAIT_MAX != 0) &&
                      (wait_cnt == WAIT_W'(FETCH_WAIT_MAX - 1));

    assign bus.cword    = cw;
    assign bus.imem_req = imem_req;

    always_comb begin
        case (ir[6:0])
            7'b0000011: itype = T_LOAD;
            7'b0010011: itype = T_IMM;
            7'b0100011: itype = T_STORE;
            7'b0110011: itype = T_REG;
            7'b0110111: itype = T_LUI;
            7'b0010111: itype = T_AUIPC;
            7'b1100011: itype = T_BRNCH;
            7'b1100111: itype = T_JALR;
            7'b1101111: itype = T_JAL;
            default:    itype = T_ILL;
        endcase
    end

    // funct7[5] selects sub/sra only for register ops and for immediate shifts-right.
    always_comb begin
        alu_op = 4'd0;
        if ((itype == T_REG) || (itype == T_IMM))
            alu_op = {ir[30] & ((itype == T_REG) || (ir[14:12] == 3'b101)), ir[14:12]};
        else if (itype == T_BRNCH)
            alu_op = 4'b1000;
    end

    always_comb begin
        state_nx = state;
        cw       = '0;
        imem_req = 1'b0;
        retire   = 1'b0;
        to_hit   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap_hit = 1'b0;
`endif
        if (state inside {DECODE, EXEC, MEM, WB}) begin
            cw.inst_type = itype;
            cw.funct3    = ir[14:12];
            cw.f7b5      = ir[30];
            cw.alu_op    = alu_op;
            cw.a_sel     = (itype == T_AUIPC) || (itype == T_JAL);
            cw.b_sel     = itype inside {T_LOAD, T_IMM, T_STORE, T_LUI, T_AUIPC, T_JAL, T_JALR};
            if (itype == T_LOAD)
                cw.wb_sel = 2'd1;
            else if (is_jump)
                cw.wb_sel = 2'd2;
            else if (itype == T_LUI)
                cw.wb_sel = 2'd3;
        end

        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    cw.ir_we = 1'b1;
                    state_nx = DECODE;
                end else if (wait_lim) begin
                    to_hit   = 1'b1;
                    state_nx = HALT;
                end
            end
            DECODE: begin
                state_nx = EXEC;
`ifdef ILLEGAL_TRAP_EN
                if (itype == T_ILL) begin
                    trap_hit = 1'b1;
                    state_nx = HALT;
                end
`endif
            end
            EXEC: begin
                if (itype == T_BRNCH) begin
                    cw.br_eval = 1'b1;
                    cw.pc_we   = 1'b1;
                    cw.pc_sel  = bus.br_taken;
                    retire     = 1'b1;
                    state_nx   = FETCH;
                end else if ((itype == T_LOAD) || (itype == T_STORE)) begin
                    state_nx = MEM;
                end else begin
                    state_nx = WB;
                end
            end
            MEM: begin
                cw.mem_rd = (itype == T_LOAD);
                cw.mem_wr = (itype != T_LOAD);
                if (bus.dmem_ready) begin
                    if (itype == T_LOAD) begin
                        state_nx = WB;
                    end else begin
                        cw.pc_we = 1'b1;
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                end else if (wait_lim) begin
                    to_hit   = 1'b1;
                    state_nx = HALT;
                end
            end
            WB: begin
                cw.rf_we  = rd_nz && (itype != T_ILL);
                cw.pc_we  = 1'b1;
                cw.pc_sel = is_jump;
                retire    = 1'b1;
                state_nx  = FETCH;
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir       <= '0;
            instret  <= '0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (cw.ir_we)
                ir <= bus.inst;
            if (retire)
                instret <= instret + PERF_CNT_W'(1);
            if (to_hit)
                timeout <= 1'b1;
            if (state_nx != state)
                wait_cnt <= '0;
            else if (stall)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trap <= 1'b0;
        else if (trap_hit)
            trap <= 1'b1;
    end
`else
    assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed-vector bench for rv32i_multicycle_ctrl (FETCH_WAIT_MAX=4, 4-bit instret).
module tb_rv32i_multicycle_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] instret;
    logic       timeout;
    logic       trap;
    logic [3:0] exp_ret;
    int         vec;
    int         miss;

    rv32i_multicycle_ctrl_if bus();

    rv32i_multicycle_ctrl #(
        .FETCH_WAIT_MAX(4),
        .PERF_CNT_W    (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .instret(instret),
        .timeout(timeout),
        .trap   (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    // Called mid-cycle in FETCH; returns mid-cycle in DECODE with inst scrambled.
    task automatic do_fetch(input string tag, input logic [31:0] i);
        bus.imem_ready = 1'b1;
        bus.inst       = i;
        #1;
        vec++;
        if (bus.imem_req !== 1'b1 || bus.cword !== 23'h000010) begin
            miss++;
            $display("FAIL %s fetch: got req=%b cword=%h expected req=1 cword=000010",
                     tag, bus.imem_req, bus.cword);
        end
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.inst       = ~i;
        #1;
    endtask

    task automatic exec_alu(input string tag, input logic [31:0] i,
                            input logic [22:0] cw_dec, input logic [22:0] cw_wb);
        do_fetch(tag, i);
        vec++;
        if (bus.cword !== cw_dec) begin
            miss++;
            $display("FAIL %s decode: got cword=%h expected %h", tag, bus.cword, cw_dec);
        end
        @(negedge clk); #1;
        vec++;
        if (bus.cword !== cw_dec) begin
            miss++;
            $display("FAIL %s exec: got cword=%h expected %h", tag, bus.cword, cw_dec);
        end
        @(negedge clk); #1;
        vec++;
        if (bus.cword !== cw_wb || instret !== exp_ret) begin
            miss++;
            $display("FAIL %s wb: got cword=%h instret=%0d expected cword=%h instret=%0d",
                     tag, bus.cword, instret, cw_wb, exp_ret);
        end
        exp_ret = exp_ret + 4'd1;
        @(negedge clk); #1;
        vec++;
        if (bus.imem_req !== 1'b1 || instret !== exp_ret) begin
            miss++;
            $display("FAIL %s retire: got req=%b instret=%0d expected req=1 instret=%0d",
                     tag, bus.imem_req, instret, exp_ret);
        end
    endtask

    task automatic exec_branch(input string tag, input logic [31:0] i, input logic taken,
                               input logic [22:0] cw_dec, input logic [22:0] cw_exec);
        do_fetch(tag, i);
        vec++;
        if (bus.cword !== cw_dec) begin
            miss++;
            $display("FAIL %s decode: got cword=%h expected %h", tag, bus.cword, cw_dec);
        end
        @(negedge clk);
        bus.br_taken = taken;
        #1;
        vec++;
        if (bus.cword !== cw_exec || instret !== exp_ret) begin
            miss++;
            $display("FAIL %s exec: got cword=%h instret=%0d expected cword=%h instret=%0d",
                     tag, bus.cword, instret, cw_exec, exp_ret);
        end
        exp_ret = exp_ret + 4'd1;
        @(negedge clk);
        bus.br_taken = 1'b0;
        #1;
        vec++;
        if (bus.imem_req !== 1'b1 || instret !== exp_ret) begin
            miss++;
            $display("FAIL %s retire: got req=%b instret=%0d expected req=1 instret=%0d",
                     tag, bus.imem_req, instret, exp_ret);
        end
    endtask

    task automatic reset_to_fetch();
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.br_taken   = 1'b0;
        rst_n          = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 4'd0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.imem_ready = 1'b0;
        bus.inst       = 32'h0;
        bus.dmem_ready = 1'b0;
        bus.br_taken   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (bus.cword !== 23'h0 || bus.imem_req !== 1'b0 || instret !== 4'd0 ||
            timeout !== 1'b0 || trap !== 1'b0) begin
            miss++;
            $display("FAIL reset: got cword=%h req=%b instret=%0d timeout=%b trap=%b expected all 0",
                     bus.cword, bus.imem_req, instret, timeout, trap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vec++;
        if (bus.cword !== 23'h0 || bus.imem_req !== 1'b0) begin
            miss++;
            $display("FAIL idle: got cword=%h req=%b expected cword=0 req=0", bus.cword, bus.imem_req);
        end
        @(negedge clk); #1;
        vec++;
        if (bus.imem_req !== 1'b1) begin
            miss++;
            $display("FAIL idle_to_fetch: got req=%b expected 1", bus.imem_req);
        end
    endtask

    task automatic test_alu_imm();
        exec_alu("addi_x3", 32'h07b20193, 23'h000201, 23'h0002a1);
    endtask

    task automatic test_load();
        do_fetch("lb", 32'h08020183);
        vec++;
        if (bus.cword !== 23'h001200) begin
            miss++;
            $display("FAIL lb decode: got cword=%h expected 001200", bus.cword);
        end
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        #1;
        vec++;
        if (bus.cword !== 23'h001200) begin
            miss++;
            $display("FAIL lb exec: got cword=%h expected 001200", bus.cword);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.dmem_ready = (k == 3);
            #1;
            vec++;
            if (bus.cword !== 23'h001600) begin
                miss++;
                $display("FAIL lb mem cycle %0d: got cword=%h expected 001600", k, bus.cword);
            end
        end
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        #1;
        vec++;
        if (bus.cword !== 23'h0012a0 || instret !== exp_ret) begin
            miss++;
            $display("FAIL lb wb: got cword=%h instret=%0d expected cword=0012a0 instret=%0d",
                     bus.cword, instret, exp_ret);
        end
        exp_ret = exp_ret + 4'd1;
        @(negedge clk); #1;
        vec++;
        if (bus.imem_req !== 1'b1 || instret !== exp_ret || timeout !== 1'b0) begin
            miss++;
            $display("FAIL lb retire: got req=%b instret=%0d timeout=%b expected req=1 instret=%0d timeout=0",
                     bus.imem_req, instret, timeout, exp_ret);
        end
    endtask

    task automatic test_branch();
        exec_branch("beq_taken",    32'h08418063, 1'b1, 23'h400006, 23'h440066);
        exec_branch("beq_nottaken", 32'h08418063, 1'b0, 23'h400006, 23'h440026);
    endtask

    task automatic test_nop_jal();
        exec_alu("addi_x0", 32'h00000013, 23'h000201, 23'h000221);
        exec_alu("jal",     32'h038031ef, 23'h00e308, 23'h00e3e8);
    endtask

    task automatic test_alu_ops();
        exec_alu("sub",   32'h403100b3, 23'h420003, 23'h4200a3);
        exec_alu("srai",  32'h40335293, 23'h6b4201, 23'h6b42a1);
        exec_alu("lui",   32'h123452b7, 23'h017204, 23'h0172a4);
        exec_alu("auipc", 32'h00000097, 23'h000305, 23'h0003a5);
    endtask

    task automatic test_store();
        do_fetch("sw", 32'h0020a423);
        vec++;
        if (bus.cword !== 23'h008202) begin
            miss++;
            $display("FAIL sw decode: got cword=%h expected 008202", bus.cword);
        end
        @(negedge clk); #1;
        vec++;
        if (bus.cword !== 23'h008202) begin
            miss++;
            $display("FAIL sw exec: got cword=%h expected 008202", bus.cword);
        end
        @(negedge clk); #1;
        vec++;
        if (bus.cword !== 23'h008a02) begin
            miss++;
            $display("FAIL sw mem wait: got cword=%h expected 008a02", bus.cword);
        end
        @(negedge clk);
        bus.dmem_ready = 1'b1;
        #1;
        vec++;
        if (bus.cword !== 23'h008a22 || instret !== exp_ret) begin
            miss++;
            $display("FAIL sw mem done: got cword=%h instret=%0d expected cword=008a22 instret=%0d",
                     bus.cword, instret, exp_ret);
        end
        exp_ret = exp_ret + 4'd1;
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        #1;
        vec++;
        if (bus.imem_req !== 1'b1 || instret !== exp_ret) begin
            miss++;
            $display("FAIL sw retire: got req=%b instret=%0d expected req=1 instret=%0d",
                     bus.imem_req, instret, exp_ret);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 16; k++)
            exec_branch("wrap", 32'h08418063, k[0], 23'h400006,
                        k[0] ? 23'h440066 : 23'h440026);
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
        do_fetch("illegal", 32'hFFFFFFFF);
        vec++;
        if (bus.cword !== 23'h03c00f || trap !== 1'b0) begin
            miss++;
            $display("FAIL illegal decode: got cword=%h trap=%b expected cword=03c00f trap=0",
                     bus.cword, trap);
        end
        repeat (2) begin
            @(negedge clk); #1;
            vec++;
            if (bus.cword !== 23'h0 || bus.imem_req !== 1'b0 || trap !== 1'b1 ||
                instret !== exp_ret) begin
                miss++;
                $display("FAIL illegal trap: got cword=%h req=%b trap=%b instret=%0d expected cword=0 req=0 trap=1 instret=%0d",
                         bus.cword, bus.imem_req, trap, instret, exp_ret);
            end
        end
`else
        exec_alu("illegal_nop", 32'hFFFFFFFF, 23'h03c00f, 23'h03c02f);
        vec++;
        if (trap !== 1'b0) begin
            miss++;
            $display("FAIL illegal trap: got trap=%b expected 0", trap);
        end
`endif
    endtask

    task automatic test_timeout();
        reset_to_fetch();
        for (int c = 0; c < 4; c++) begin
            vec++;
            if (bus.imem_req !== 1'b1 || timeout !== 1'b0) begin
                miss++;
                $display("FAIL timeout stall %0d: got req=%b timeout=%b expected req=1 timeout=0",
                         c, bus.imem_req, timeout);
            end
            @(negedge clk); #1;
        end
        vec++;
        if (timeout !== 1'b1 || bus.cword !== 23'h0 || bus.imem_req !== 1'b0) begin
            miss++;
            $display("FAIL timeout halt: got timeout=%b cword=%h req=%b expected timeout=1 cword=0 req=0",
                     timeout, bus.cword, bus.imem_req);
        end
        bus.imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (timeout !== 1'b1 || bus.cword !== 23'h0 || bus.imem_req !== 1'b0) begin
            miss++;
            $display("FAIL halt hold: got timeout=%b cword=%h req=%b expected timeout=1 cword=0 req=0",
                     timeout, bus.cword, bus.imem_req);
        end
        bus.imem_ready = 1'b0;
        rst_n          = 1'b0;
        #1;
        vec++;
        if (timeout !== 1'b0 || bus.cword !== 23'h0) begin
            miss++;
            $display("FAIL halt reset: got timeout=%b cword=%h expected timeout=0 cword=0",
                     timeout, bus.cword);
        end
    endtask

    task automatic test_reset_mid_mem();
        reset_to_fetch();
        exec_alu("pre_addi", 32'h07b20193, 23'h000201, 23'h0002a1);
        do_fetch("lb_abort", 32'h08020183);
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        #1;
        @(negedge clk); #1;
        vec++;
        if (bus.cword !== 23'h001600) begin
            miss++;
            $display("FAIL abort mem: got cword=%h expected 001600", bus.cword);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vec++;
        if (bus.cword !== 23'h0 || bus.imem_req !== 1'b0 || instret !== 4'd0 ||
            timeout !== 1'b0 || trap !== 1'b0) begin
            miss++;
            $display("FAIL abort reset: got cword=%h req=%b instret=%0d timeout=%b trap=%b expected all 0",
                     bus.cword, bus.imem_req, instret, timeout, trap);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 4'd0;
        @(negedge clk); #1;
        vec++;
        if (bus.imem_req !== 1'b1) begin
            miss++;
            $display("FAIL abort restart: got req=%b expected 1", bus.imem_req);
        end
        exec_alu("post_addi", 32'h07b20193, 23'h000201, 23'h0002a1);
    endtask

    initial begin
        vec     = 0;
        miss    = 0;
        exp_ret = 4'd0;
        test_reset();
        test_alu_imm();
        test_load();
        test_branch();
        test_nop_jal();
        test_alu_ops();
        test_store();
        test_wrap();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
